tinker_issue_controller: RTL and testbench
==========================================

Name: tinker_issue_controller

Overview:
- Multi-cycle sequencer in front of the tinker integer/float ALU and 32x64 register file.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it.
- Drives register-file addresses, ALU op/select controls and immediate, and waits a per-class latency.
- Pulses the register-file write enable exactly once per retired instruction, replacing the combinational write path with a clocked, ordered one.

Parameters:
- MUL_LAT, 4, EXEC cycles for integer mul (0x1c); legal range 1..31.
- DIV_LAT, 16, EXEC cycles for integer div (0x1d); legal range 1..31.
- FP_LAT, 3, EXEC cycles for addf/subf/mulf/divf (0x14-0x17); legal range 1..31.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction present.
- instr  in  32  [31:27] opcode, [26:22] rd, [21:17] rs, [16:12] rt, [11:0] L.
- instr_ready  out  1  controller can accept.
- rf_rs_addr  out  5  register-file read port A.
- rf_rt_addr  out  5  register-file read port B.
- rf_rd_addr  out  5  write address.
- rf_we  out  1  write-enable pulse.
- alu_op  out  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 not.
- alu_shift  out  2  00 none, 01 right, 10 left (overrides alu_op).
- alu_is_float  out  1  float path select.
- alu_use_imm  out  1  operand B = zero-extended imm.
- imm  out  12  literal.
- busy  out  1  high in any state other than IDLE.
- retire  out  1  one-cycle pulse in WB.
- illegal  out  1  one-cycle pulse in WB for an undefined opcode.
- perf_retired  out  32  see Optional Feature.
- perf_stall  out  32  see Optional Feature.

Behaviour:
- Reset is synchronous and active-high on clk; ports are named clk and reset.
- Reset values: state=IDLE, instr_ready=1, all other outputs 0, internal instruction register cleared.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to DECODE.
  - No handshake, stay in IDLE.
- DECODE (1 cycle):
  - Drive address, ALU and imm outputs from the latched instruction; they are held stable through WB.
  - Load the latency counter with L-1, where L is 1 for add/sub/logic/shift/mov, MUL_LAT, DIV_LAT or FP_LAT.
  - Legal opcode: go to EXEC. Illegal opcode: go directly to WB.
- EXEC:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to WB; EXEC therefore lasts exactly L cycles.
- WB (1 cycle):
  - retire=1.
  - rf_we=1 if opcode is legal and rd!=0, else rf_we=0.
  - illegal=1 for an undefined opcode.
  - Next state is IDLE.
- Latency: handshake in cycle 0; DECODE in cycle 1; EXEC in cycles 2..L+1; WB in cycle L+2; instr_ready=1 again in cycle L+3.
- Throughput is one instruction per L+3 cycles.
- In any non-IDLE state, instr_ready=0 and instr is ignored.
- Decode map, opcode -> controls:
  - 0x18 add: op 000.
  - 0x19 addi: op 000, imm.
  - 0x1a sub: op 001.
  - 0x1b subi: op 001, imm.
  - 0x1c mul: op 010.
  - 0x1d div: op 011.
  - 0x00 and / 0x01 or / 0x02 xor / 0x03 not: op 100 / 101 / 110 / 111.
  - 0x04 shftr: shift 01.
  - 0x05 shftri: shift 01, imm.
  - 0x06 shftl: shift 10.
  - 0x07 shftli: shift 10, imm.
  - 0x11 mov rd,rs: op 000, rt_addr=0.
  - 0x12 mov rd,L: op 000, imm, rs_addr=0.
  - 0x14-0x17 addf/subf/mulf/divf: op 000-011, float=1.
  - All other opcodes are illegal.
- Immediate forms other than 0x12 (addi, subi, shftri, shftli): rf_rs_addr = rd field, because the destination is also the source.
- For illegal opcodes, alu_op, alu_shift, alu_is_float and alu_use_imm are 0.
- Reset asserted mid-instruction (any state):
  - Abandon the instruction and return to IDLE next cycle.
  - rf_we and retire are not asserted.
- Latency parameter of 0 is treated as 1.

Optional Feature:
- Macro: TINKER_ISSUE_PERF_EN.
- Defined:
  - perf_retired increments by 1 on every retire pulse, including illegal instructions.
  - perf_stall increments by 1 every cycle that instr_valid=1 && instr_ready=0.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset, then idle -> instr_ready=1, busy=0, rf_we=0, all outputs 0.
- add r3,r1,r2 (0xC0C22000) accepted in cycle 0:
  - DECODE in cycle 1: rs=1, rt=2, rd=3, alu_op=000.
  - rf_we=1 and retire=1 in cycle 3.
  - instr_ready=1 in cycle 4.
- div with DIV_LAT=16:
  - busy for 18 cycles; rf_we fires exactly once, in cycle 18.
  - instr_valid held high throughout: no second accept before cycle 19.
  - perf_stall=17 with TINKER_ISSUE_PERF_EN defined.
- addi r5,0x7FF:
  - rs=5, rd=5, alu_use_imm=1, imm=0x7FF, rf_we in cycle 3.
- Opcode 0x1F:
  - illegal=1 and retire=1 in cycle 2, rf_we=0.
  - Any rd (including rd=0) produces no write.
- reset asserted in cycle 5 of a mulf (FP_LAT=3) or div:
  - No rf_we pulse; IDLE in the following cycle.
  - perf counters read 0.

Source files
------------

// File: rtl/tinker_issue_controller_if.sv
// Instruction handshake between the fetch side and tinker_issue_controller.
interface tinker_issue_controller_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    // Fetch side presents instructions.
    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    // Controller side accepts instructions.
    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/tinker_issue_controller.sv
// tinker_issue_controller: multi-cycle issue sequencer for the tinker ALU and
// 32x64 register file. One instruction in flight: IDLE -> DECODE -> EXEC -> WB.
// Optional feature macro: TINKER_ISSUE_PERF_EN (retire/stall perf counters).
module tinker_issue_controller #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16,
    parameter int unsigned FP_LAT  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    tinker_issue_controller_if.slave    instr_if,
    output logic [4:0]                  rf_rs_addr,
    output logic [4:0]                  rf_rt_addr,
    output logic [4:0]                  rf_rd_addr,
    output logic                        rf_we,
    output logic [2:0]                  alu_op,
    output logic [1:0]                  alu_shift,
    output logic                        alu_is_float,
    output logic                        alu_use_imm,
    output logic [11:0]                 imm,
    output logic                        busy,
    output logic                        retire,
    output logic                        illegal,
    output logic [31:0]                 perf_retired,
    output logic [31:0]                 perf_stall
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned OPC_W = 5;

    // A latency of 0 behaves like 1.
    localparam int unsigned MUL_L = (MUL_LAT == 0) ? 1 : MUL_LAT;
    localparam int unsigned DIV_L = (DIV_LAT == 0) ? 1 : DIV_LAT;
    localparam int unsigned FP_L  = (FP_LAT  == 0) ? 1 : FP_LAT;

    // Counter preload is L-1 so EXEC lasts exactly L cycles.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_L - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_L - 1);
    localparam logic [CNT_W-1:0] FP_CNT  = CNT_W'(FP_L - 1);

    localparam logic [OPC_W-1:0] OPC_AND    = 5'h00;
    localparam logic [OPC_W-1:0] OPC_OR     = 5'h01;
    localparam logic [OPC_W-1:0] OPC_XOR    = 5'h02;
    localparam logic [OPC_W-1:0] OPC_NOT    = 5'h03;
    localparam logic [OPC_W-1:0] OPC_SHFTR  = 5'h04;
    localparam logic [OPC_W-1:0] OPC_SHFTRI = 5'h05;
    localparam logic [OPC_W-1:0] OPC_SHFTL  = 5'h06;
    localparam logic [OPC_W-1:0] OPC_SHFTLI = 5'h07;
    localparam logic [OPC_W-1:0] OPC_MOVR   = 5'h11;
    localparam logic [OPC_W-1:0] OPC_MOVL   = 5'h12;
    localparam logic [OPC_W-1:0] OPC_ADDF   = 5'h14;
    localparam logic [OPC_W-1:0] OPC_SUBF   = 5'h15;
    localparam logic [OPC_W-1:0] OPC_MULF   = 5'h16;
    localparam logic [OPC_W-1:0] OPC_DIVF   = 5'h17;
    localparam logic [OPC_W-1:0] OPC_ADD    = 5'h18;
    localparam logic [OPC_W-1:0] OPC_ADDI   = 5'h19;
    localparam logic [OPC_W-1:0] OPC_SUB    = 5'h1a;
    localparam logic [OPC_W-1:0] OPC_SUBI   = 5'h1b;
    localparam logic [OPC_W-1:0] OPC_MUL    = 5'h1c;
    localparam logic [OPC_W-1:0] OPC_DIV    = 5'h1d;

    localparam logic [1:0] SH_NONE  = 2'b00;
    localparam logic [1:0] SH_RIGHT = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    typedef struct packed {
        logic        legal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [1:0]  sh;
        logic        fl;
        logic        use_imm;
        logic [11:0] imm;
    } dec_t;

    // Opcode to datapath controls; immediate forms other than mov rd,L read rd.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t            d;
        logic [OPC_W-1:0] opc;
        opc       = w[31:27];
        d         = '0;
        d.legal   = 1'b1;
        d.rd      = w[26:22];
        d.rs      = w[21:17];
        d.rt      = w[16:12];
        d.imm     = w[11:0];
        case (opc)
            OPC_ADD:  d.op = 3'b000;
            OPC_ADDI: begin
                d.op      = 3'b000;
                d.use_imm = 1'b1;
                d.rs      = w[26:22];
            end
            OPC_SUB:  d.op = 3'b001;
            OPC_SUBI: begin
                d.op      = 3'b001;
                d.use_imm = 1'b1;
                d.rs      = w[26:22];
            end
            OPC_MUL:  d.op = 3'b010;
            OPC_DIV:  d.op = 3'b011;
            OPC_AND, OPC_OR, OPC_XOR, OPC_NOT:
                d.op = {1'b1, opc[1:0]};
            OPC_SHFTR: d.sh = SH_RIGHT;
            OPC_SHFTRI: begin
                d.sh      = SH_RIGHT;
                d.use_imm = 1'b1;
                d.rs      = w[26:22];
            end
            OPC_SHFTL: d.sh = SH_LEFT;
            OPC_SHFTLI: begin
                d.sh      = SH_LEFT;
                d.use_imm = 1'b1;
                d.rs      = w[26:22];
            end
            OPC_MOVR: begin
                d.op = 3'b000;
                d.rt = 5'd0;
            end
            OPC_MOVL: begin
                d.op      = 3'b000;
                d.use_imm = 1'b1;
                d.rs      = 5'd0;
            end
            OPC_ADDF, OPC_SUBF, OPC_MULF, OPC_DIVF: begin
                d.op = {1'b0, opc[1:0]};
                d.fl = 1'b1;
            end
            default: begin
                d.legal = 1'b0;
                d.op    = 3'b000;
                d.sh    = SH_NONE;
            end
        endcase
        return d;
    endfunction

    // EXEC counter preload per instruction class.
    function automatic logic [CNT_W-1:0] lat_cnt(input logic [OPC_W-1:0] opc);
        logic [CNT_W-1:0] c;
        case (opc)
            OPC_MUL:                                 c = MUL_CNT;
            OPC_DIV:                                 c = DIV_CNT;
            OPC_ADDF, OPC_SUBF, OPC_MULF, OPC_DIVF:  c = FP_CNT;
            default:                                 c = '0;
        endcase
        return c;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [OPC_W-1:0] opc_q;
    logic             legal_q;
    logic             ready_q;
    dec_t             dec_c;

    assign instr_if.instr_ready = ready_q;

    // Decode of the word currently on the bus, captured on the handshake.
    always_comb begin
        dec_c = decode(instr_if.instr);
    end

    // Sequencer: latches the instruction, counts latency, pulses writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            busy         <= 1'b0;
            cnt          <= '0;
            opc_q        <= '0;
            legal_q      <= 1'b0;
            rf_rs_addr   <= '0;
            rf_rt_addr   <= '0;
            rf_rd_addr   <= '0;
            rf_we        <= 1'b0;
            alu_op       <= '0;
            alu_shift    <= '0;
            alu_is_float <= 1'b0;
            alu_use_imm  <= 1'b0;
            imm          <= '0;
            retire       <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_if.instr_valid && ready_q) begin
                        opc_q        <= instr_if.instr[31:27];
                        legal_q      <= dec_c.legal;
                        rf_rs_addr   <= dec_c.rs;
                        rf_rt_addr   <= dec_c.rt;
                        rf_rd_addr   <= dec_c.rd;
                        alu_op       <= dec_c.op;
                        alu_shift    <= dec_c.sh;
                        alu_is_float <= dec_c.fl;
                        alu_use_imm  <= dec_c.use_imm;
                        imm          <= dec_c.imm;
                        ready_q      <= 1'b0;
                        busy         <= 1'b1;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    cnt <= lat_cnt(opc_q);
                    if (legal_q) begin
                        state <= EXEC;
                    end else begin
                        retire  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= WB;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        retire <= 1'b1;
                        rf_we  <= (rf_rd_addr != 5'd0);
                        state  <= WB;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WB: begin
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef TINKER_ISSUE_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    // Retired-instruction and blocked-offer counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
            if (instr_if.instr_valid && !ready_q) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_retired = retired_q;
    assign perf_stall   = stall_q;
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_tinker_issue_controller.sv
// Bench for tinker_issue_controller: transaction-level model plus directed vectors.
module tb_tinker_issue_controller;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 16;
    localparam int unsigned FP_LAT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rf_rs_addr, rf_rt_addr, rf_rd_addr;
    logic        rf_we, alu_is_float, alu_use_imm, busy, retire, illegal;
    logic [2:0]  alu_op;
    logic [1:0]  alu_shift;
    logic [11:0] imm;
    logic [31:0] perf_retired, perf_stall;

    int n_cmp = 0;
    int n_err = 0;

    tinker_issue_controller_if bus();

    tinker_issue_controller #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .FP_LAT (FP_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_if    (bus),
        .rf_rs_addr  (rf_rs_addr),
        .rf_rt_addr  (rf_rt_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .alu_shift   (alu_shift),
        .alu_is_float(alu_is_float),
        .alu_use_imm (alu_use_imm),
        .imm         (imm),
        .busy        (busy),
        .retire      (retire),
        .illegal     (illegal),
        .perf_retired(perf_retired),
        .perf_stall  (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        legal;
        int unsigned lat;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [1:0]  sh;
        logic        fl;
        logic        ui;
        logic [11:0] imm;
    } exp_t;

    function automatic int unsigned eff(input int unsigned l);
        return (l == 0) ? 1 : l;
    endfunction

    // What the datapath controls must be for an instruction word.
    function automatic exp_t mdecode(input logic [31:0] w);
        exp_t e;
        int   o;
        o       = int'(w[31:27]);
        e       = '0;
        e.legal = 1'b1;
        e.lat   = 1;
        e.rd    = w[26:22];
        e.rs    = w[21:17];
        e.rt    = w[16:12];
        e.imm   = w[11:0];
        if (o == 'h18 || o == 'h19)      e.op = 3'd0;
        else if (o == 'h1a || o == 'h1b) e.op = 3'd1;
        else if (o == 'h1c) begin e.op = 3'd2; e.lat = eff(MUL_LAT); end
        else if (o == 'h1d) begin e.op = 3'd3; e.lat = eff(DIV_LAT); end
        else if (o <= 3)                 e.op = 3'(4 + o);
        else if (o >= 4 && o <= 7)       e.sh = (o >= 6) ? 2'd2 : 2'd1;
        else if (o == 'h11)              e.rt = 5'd0;
        else if (o == 'h12)              e.rs = 5'd0;
        else if (o >= 'h14 && o <= 'h17) begin
            e.op  = 3'(o - 'h14);
            e.fl  = 1'b1;
            e.lat = eff(FP_LAT);
        end else begin
            e.legal = 1'b0;
        end
        e.ui = (o == 'h19 || o == 'h1b || o == 5 || o == 7 || o == 'h12);
        if (e.ui && o != 'h12) e.rs = e.rd;
        return e;
    endfunction

    // Cycle number (relative to the handshake) at which writeback happens.
    function automatic int wb_of(input exp_t e);
        return e.legal ? int'(e.lat) + 2 : 2;
    endfunction

    logic        mdl_ok   = 1'b0;
    logic        m_active = 1'b0;
    int          m_k      = 0;
    exp_t        m_exp    = '0;
    logic [31:0] m_ret    = '0;
    logic [31:0] m_stall  = '0;

    // Track which cycle of which instruction we are in.
    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_ret    <= '0;
            m_stall  <= '0;
            mdl_ok   <= 1'b1;
        end else begin
            if (m_active && m_k == wb_of(m_exp)) m_ret <= m_ret + 32'd1;
            if (bus.instr_valid && m_active)      m_stall <= m_stall + 32'd1;
            if (m_active) begin
                if (m_k == wb_of(m_exp)) m_active <= 1'b0;
                else                      m_k <= m_k + 1;
            end else if (bus.instr_valid) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_exp    <= mdecode(bus.instr);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic        ret_e;
        logic [31:0] er, es;
        if (mdl_ok) begin
            ret_e = m_active && (m_k == wb_of(m_exp));
`ifdef TINKER_ISSUE_PERF_EN
            er = m_ret;
            es = m_stall;
`else
            er = '0;
            es = '0;
`endif
            chk("busy",        32'(busy),            32'(m_active));
            chk("instr_ready", 32'(bus.instr_ready), 32'(!m_active));
            chk("retire",      32'(retire),          32'(ret_e));
            chk("illegal",     32'(illegal),         32'(ret_e && !m_exp.legal));
            chk("rf_we",       32'(rf_we),           32'(ret_e && m_exp.legal && m_exp.rd != 5'd0));
            chk("perf_retired", perf_retired, er);
            chk("perf_stall",   perf_stall,   es);
            if (m_active) begin
                chk("rf_rs_addr",   32'(rf_rs_addr),   32'(m_exp.rs));
                chk("rf_rt_addr",   32'(rf_rt_addr),   32'(m_exp.rt));
                chk("rf_rd_addr",   32'(rf_rd_addr),   32'(m_exp.rd));
                chk("alu_op",       32'(alu_op),       32'(m_exp.op));
                chk("alu_shift",    32'(alu_shift),    32'(m_exp.sh));
                chk("alu_is_float", 32'(alu_is_float), 32'(m_exp.fl));
                chk("alu_use_imm",  32'(alu_use_imm),  32'(m_exp.ui));
                chk("imm",          32'(imm),          32'(m_exp.imm));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] o, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [11:0] l);
        return {o, rd, rs, rt, l};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0]  sweep [18];
        logic [31:0] ill   [2];
        logic [31:0] rst_w [2];
        int          busy_n, we_n, we_cyc;

        sweep = '{5'h1a, 5'h1b, 5'h1c, 5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                  5'h06, 5'h07, 5'h11, 5'h12, 5'h14, 5'h15, 5'h17, 5'h08, 5'h13};
        ill   = '{32'hF8000000, 32'hF9800000};
        rst_w = '{32'hB1C22000, 32'hE9022000};

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        reset           = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_ready",  32'(bus.instr_ready), 32'd1);
        chk("rst_busy",   32'(busy),            32'd0);
        chk("rst_rf_we",  32'(rf_we),           32'd0);
        chk("rst_rs",     32'(rf_rs_addr),      32'd0);
        chk("rst_alu_op", 32'(alu_op),          32'd0);
        chk("rst_imm",    32'(imm),             32'd0);
        tick();

        // add r3,r1,r2: cycle 0 handshake.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'hC0C22000;
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("add_rs", 32'(rf_rs_addr), 32'd1);
        chk("add_rt", 32'(rf_rt_addr), 32'd2);
        chk("add_rd", 32'(rf_rd_addr), 32'd3);
        chk("add_op", 32'(alu_op),     32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("add_we_c3",     32'(rf_we),  32'd1);
        chk("add_retire_c3", 32'(retire), 32'd1);
        tick();
        @(negedge clk);
        chk("add_ready_c4", 32'(bus.instr_ready), 32'd1);
        tick();

        // addi r5,0x7FF with a distinct rs field.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'hC95207FF;
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("addi_rs",  32'(rf_rs_addr),  32'd5);
        chk("addi_rd",  32'(rf_rd_addr),  32'd5);
        chk("addi_ui",  32'(alu_use_imm), 32'd1);
        chk("addi_imm", 32'(imm),         32'h7FF);
        tick();
        tick();
        @(negedge clk);
        chk("addi_we_c3", 32'(rf_we), 32'd1);
        tick();

        // Undefined opcode 0x1F, rd=0 and rd=6.
        for (int i = 0; i < 2; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = ill[i];
            tick();
            bus.instr_valid = 1'b0;
            @(negedge clk);
            chk("ill_alu_op", 32'(alu_op),      32'd0);
            chk("ill_ui",     32'(alu_use_imm), 32'd0);
            tick();
            @(negedge clk);
            chk("ill_illegal_c2", 32'(illegal), 32'd1);
            chk("ill_retire_c2",  32'(retire),  32'd1);
            chk("ill_we_c2",      32'(rf_we),   32'd0);
            tick();
            @(negedge clk);
            chk("ill_ready_c3", 32'(bus.instr_ready), 32'd1);
            tick();
        end

        // Opcode sweep, checked by the model every cycle.
        for (int i = 0; i < 18; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = mk(sweep[i], 5'(i + 1), 5'(i + 7), 5'(31 - i), 12'(i * 171));
            tick();
            bus.instr_valid = 1'b0;
            wait_idle();
        end
        // add to r0 retires without a write.
        bus.instr_valid = 1'b1;
        bus.instr       = mk(5'h18, 5'd0, 5'd4, 5'd9, 12'h123);
        tick();
        bus.instr_valid = 1'b0;
        wait_idle();

        // div with instr_valid held high.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'hE9022000;
        tick();
        busy_n = 0;
        we_n   = 0;
        we_cyc = -1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (rf_we) begin
                we_n++;
                we_cyc = c;
            end
`ifdef TINKER_ISSUE_PERF_EN
            if (c == 18) chk("div_perf_stall_c18", perf_stall, 32'd17);
`endif
            tick();
        end
        @(negedge clk);
        chk("div_ready_c19", 32'(bus.instr_ready), 32'd1);
        chk("div_busy_c19",  32'(busy),            32'd0);
        chk("div_busy_cycles", 32'(busy_n), 32'd18);
        chk("div_we_count",    32'(we_n),   32'd1);
        chk("div_we_cycle",    32'(we_cyc), 32'd18);
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("div2_accepted", 32'(busy), 32'd1);
        wait_idle();

        // Reset in the middle of a mulf and a div.
        for (int i = 0; i < 2; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = rst_w[i];
            tick();
            bus.instr_valid = 1'b0;
            tick();
            tick();
            tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clk);
            chk("rst_mid_we",      32'(rf_we),           32'd0);
            chk("rst_mid_busy",    32'(busy),            32'd0);
            chk("rst_mid_ready",   32'(bus.instr_ready), 32'd1);
            chk("rst_mid_retired", perf_retired,         32'd0);
            chk("rst_mid_stall",   perf_stall,           32'd0);
            tick();
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
